// File: rtl/prog_fetch_unit.sv
// Program memory plus instruction-fetch stage: loads a program while le_pm=1, then fetches the
// word at prog_counter and issues it to the execution control unit over a valid/ready handshake.
module prog_fetch_unit #(
   parameter int unsigned INSTR_W = 28,
   parameter int unsigned DEPTH   = 32,
   parameter int unsigned ADDR_W  = 5,
   parameter logic [3:0]  HALT_OP = 4'hF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               le_pm,
   input  logic               load_we,
   input  logic [ADDR_W-1:0]  load_addr,
   input  logic [INSTR_W-1:0] load_data,
   input  logic [ADDR_W-1:0]  prog_counter,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instruction,
   output logic               instr_valid,
   output logic [ADDR_W:0]    prog_len,
   output logic               done
);

   typedef enum logic [2:0] {StIdle, StLoad, StFetch, StIssue, StDone} state_e;

   state_e             state_q;
   logic [INSTR_W-1:0] mem [DEPTH];
   logic [INSTR_W-1:0] fetch_word;
   logic [ADDR_W:0]    load_end;
   logic [ADDR_W:0]    pc_ext;

   assign fetch_word = mem[prog_counter];
   assign load_end   = {1'b0, load_addr} + (ADDR_W+1)'(1);
   assign pc_ext     = {1'b0, prog_counter};

   // Memory contents survive reset; only writes in load mode touch them.
   always_ff @(posedge clk) begin
      if (state_q == StLoad && le_pm && load_we) begin
         mem[load_addr] <= load_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         instruction <= '0;
         instr_valid <= 1'b0;
         prog_len    <= '0;
         done        <= 1'b0;
      end else if (le_pm && state_q != StLoad) begin
         // Load request pre-empts everything, dropping any in-flight instruction.
         state_q     <= StLoad;
         instr_valid <= 1'b0;
         prog_len    <= '0;
         done        <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: state_q <= StIdle;
            StLoad: begin
               if (le_pm) begin
                  if (load_we && load_end > prog_len) begin
                     prog_len <= load_end;
                  end
               end else if (prog_len != '0) begin
                  state_q <= StFetch;
               end else begin
                  state_q <= StDone;
                  done    <= 1'b1;
               end
            end
            StFetch: begin
               if (pc_ext >= prog_len) begin
                  state_q <= StDone;
                  done    <= 1'b1;
               end else begin
                  instruction <= fetch_word;
                  if (fetch_word[INSTR_W-1 -: 4] == HALT_OP) begin
                     state_q <= StDone;
                     done    <= 1'b1;
                  end else begin
                     state_q     <= StIssue;
                     instr_valid <= 1'b1;
                  end
               end
            end
            StIssue: begin
               if (instr_ready) begin
                  instr_valid <= 1'b0;
                  state_q     <= StFetch;
               end
            end
            StDone: begin
               done        <= 1'b1;
               instr_valid <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_fetch_unit.sv
// Self-checking bench for prog_fetch_unit: directed scenarios plus randomized programs checked
// against a behavioural program/consumer model.
module tb_prog_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        le_pm;
   logic        load_we;
   logic [4:0]  load_addr;
   logic [27:0] load_data;
   logic [4:0]  prog_counter;
   logic        instr_ready;
   logic [27:0] instruction;
   logic        instr_valid;
   logic [5:0]  prog_len;
   logic        done;

   int checks   = 0;
   int failures = 0;

   logic [27:0] model_mem [32];
   int          model_len;

   prog_fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .le_pm       (le_pm),
      .load_we     (load_we),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .prog_counter(prog_counter),
      .instr_ready (instr_ready),
      .instruction (instruction),
      .instr_valid (instr_valid),
      .prog_len    (prog_len),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic enter_load();
      le_pm       = 1'b1;
      load_we     = 1'b0;
      instr_ready = 1'b0;
      tick();
      model_len = 0;
   endtask

   task automatic write_word(input logic [4:0] a, input logic [27:0] d);
      load_we   = 1'b1;
      load_addr = a;
      load_data = d;
      tick();
      load_we      = 1'b0;
      model_mem[a] = d;
      if (int'(a) + 1 > model_len) model_len = int'(a) + 1;
   endtask

   // After this the unit is in its first fetch cycle.
   task automatic leave_load();
      le_pm   = 1'b0;
      load_we = 1'b0;
      tick();
   endtask

   function automatic bit model_issues(input logic [4:0] pc);
      return (int'(pc) < model_len) && (model_mem[pc][27:24] != 4'hF);
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; le_pm = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
      prog_counter = '0; instr_ready = 1'b0;
      #7;
      checks++;
      if ({instruction, instr_valid, prog_len, done} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got instr=%h valid=%b len=%0d done=%b, want all zero",
                  instruction, instr_valid, prog_len, done);
      end
      #1 rst_n = 1'b1;
      repeat (3) tick();
      checks++;
      if ({instr_valid, done, prog_len} !== '0) begin
         failures++;
         $display("FAIL idle_stays: got valid=%b done=%b len=%0d, want 0/0/0",
                  instr_valid, done, prog_len);
      end
   endtask

   task automatic test_basic();
      enter_load();
      write_word(5'd0, 28'h0010A00);
      write_word(5'd1, 28'h1070605);
      prog_counter = 5'd0;
      leave_load();
      tick();
      checks++;
      if ({instr_valid, instruction} !== {1'b1, 28'h0010A00}) begin
         failures++;
         $display("FAIL basic_first: got valid=%b instr=%h, want 1/0010a00",
                  instr_valid, instruction);
      end
      instr_ready = 1'b1; tick(); instr_ready = 1'b0;
      checks++;
      if (instr_valid !== 1'b0) begin
         failures++;
         $display("FAIL basic_drop_after_accept: got valid=%b, want 0", instr_valid);
      end
      prog_counter = 5'd1;
      tick();
      checks++;
      if ({instr_valid, instruction} !== {1'b1, 28'h1070605}) begin
         failures++;
         $display("FAIL basic_second: got valid=%b instr=%h, want 1/1070605",
                  instr_valid, instruction);
      end
      instr_ready = 1'b1; tick(); instr_ready = 1'b0;
      prog_counter = 5'd2;
      tick();
      checks++;
      if ({done, instr_valid, prog_len} !== {1'b1, 1'b0, 6'd2}) begin
         failures++;
         $display("FAIL basic_end: got done=%b valid=%b len=%0d, want 1/0/2",
                  done, instr_valid, prog_len);
      end
   endtask

   task automatic test_backpressure();
      logic [27:0] w;
      w = {4'h2, 24'($urandom)};
      enter_load();
      write_word(5'd0, w);
      prog_counter = 5'd0;
      leave_load();
      tick();
      for (int i = 0; i < 5; i++) begin
         prog_counter = 5'($urandom);
         tick();
         checks++;
         if ({instr_valid, instruction} !== {1'b1, w}) begin
            failures++;
            $display("FAIL backpressure_hold[%0d]: got valid=%b instr=%h, want 1/%h",
                     i, instr_valid, instruction, w);
         end
      end
      instr_ready = 1'b1; tick(); instr_ready = 1'b0;
      prog_counter = 5'd1;
      tick();
      checks++;
      if ({instr_valid, done} !== 2'b01) begin
         failures++;
         $display("FAIL backpressure_single_accept: got valid=%b done=%b, want 0/1",
                  instr_valid, done);
      end
   endtask

   task automatic test_halt();
      enter_load();
      write_word(5'd0, 28'h0010A00);
      write_word(5'd1, 28'hF000000);
      write_word(5'd2, 28'h1070605);
      prog_counter = 5'd0;
      leave_load();
      tick();
      checks++;
      if ({instr_valid, instruction} !== {1'b1, 28'h0010A00}) begin
         failures++;
         $display("FAIL halt_first: got valid=%b instr=%h, want 1/0010a00",
                  instr_valid, instruction);
      end
      instr_ready = 1'b1; tick(); instr_ready = 1'b0;
      prog_counter = 5'd1;
      tick();
      checks++;
      if ({done, instr_valid} !== 2'b10) begin
         failures++;
         $display("FAIL halt_stop: got done=%b valid=%b, want 1/0", done, instr_valid);
      end
      prog_counter = 5'd2;
      instr_ready  = 1'b1;
      repeat (4) tick();
      instr_ready = 1'b0;
      checks++;
      if ({done, instr_valid} !== 2'b10) begin
         failures++;
         $display("FAIL halt_stays_done: got done=%b valid=%b, want 1/0", done, instr_valid);
      end
   endtask

   task automatic test_jump_loop();
      enter_load();
      write_word(5'd0, 28'h6000000);
      prog_counter = 5'd0;
      leave_load();
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if ({instr_valid, instruction, done} !== {1'b1, 28'h6000000, 1'b0}) begin
            failures++;
            $display("FAIL jump_loop[%0d]: got valid=%b instr=%h done=%b, want 1/6000000/0",
                     i, instr_valid, instruction, done);
         end
         instr_ready = 1'b1; tick(); instr_ready = 1'b0;
         prog_counter = model_mem[0][20:16];
      end
   endtask

   task automatic test_reload();
      enter_load();
      write_word(5'd0, 28'h3111111);
      write_word(5'd1, 28'h3222222);
      prog_counter = 5'd1;
      leave_load();
      tick();
      le_pm = 1'b1;
      tick();
      model_len = 0;
      checks++;
      if ({instr_valid, prog_len, done} !== '0) begin
         failures++;
         $display("FAIL reload_clear: got valid=%b len=%0d done=%b, want 0/0/0",
                  instr_valid, prog_len, done);
      end
      write_word(5'd0, 28'h4333333);
      // Writes with le_pm low must be ignored from here on.
      le_pm = 1'b0; load_we = 1'b1; load_addr = 5'd0; load_data = 28'h5444444;
      prog_counter = 5'd0;
      tick();
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({instr_valid, instruction} !== {1'b1, 28'h4333333}) begin
            failures++;
            $display("FAIL reload_ignore_we[%0d]: got valid=%b instr=%h, want 1/4333333",
                     i, instr_valid, instruction);
         end
         instr_ready = 1'b1; tick(); instr_ready = 1'b0;
      end
      load_we = 1'b0;
      checks++;
      if (prog_len !== 6'd1) begin
         failures++;
         $display("FAIL reload_len: got %0d, want 1", prog_len);
      end
   endtask

   task automatic test_async_reset();
      enter_load();
      write_word(5'd3, 28'h7123456);
      prog_counter = 5'd3;
      leave_load();
      tick();
      checks++;
      if (instr_valid !== 1'b1) begin
         failures++;
         $display("FAIL async_pre_valid: got %b, want 1", instr_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({instr_valid, done, prog_len} !== '0) begin
         failures++;
         $display("FAIL async_reset_clear: got valid=%b done=%b len=%0d, want 0/0/0",
                  instr_valid, done, prog_len);
      end
      #1 rst_n = 1'b1;
      model_len = 0;
      repeat (3) tick();
      checks++;
      if ({instr_valid, done} !== 2'b00) begin
         failures++;
         $display("FAIL async_idle: got valid=%b done=%b, want 0/0", instr_valid, done);
      end
   endtask

   task automatic test_random();
      logic [4:0]  a;
      logic [4:0]  pc;
      logic [27:0] w;
      int          nw;
      for (int round = 0; round < 12; round++) begin
         enter_load();
         if (round == 0) begin
            for (int i = 0; i < 32; i++) write_word(5'(31 - i), {4'($urandom_range(0, 14)),
                                                                  24'($urandom)});
         end else begin
            nw = $urandom_range(1, 10);
            for (int i = 0; i < nw; i++) begin
               a = 5'($urandom_range(0, 31));
               w = 28'($urandom);
               write_word(a, w);
            end
         end
         checks++;
         if (int'(prog_len) != model_len) begin
            failures++;
            $display("FAIL rand_len[%0d]: got %0d, want %0d", round, prog_len, model_len);
         end
         leave_load();
         for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 4) != 0) pc = 5'($urandom_range(0, model_len - 1));
            else pc = 5'($urandom);
            prog_counter = pc;
            tick();
            if (model_issues(pc)) begin
               checks++;
               if ({instr_valid, instruction, done} !== {1'b1, model_mem[pc], 1'b0}) begin
                  failures++;
                  $display("FAIL rand_issue[%0d.%0d]: pc=%0d got valid=%b instr=%h, want 1/%h",
                           round, k, pc, instr_valid, instruction, model_mem[pc]);
               end
               repeat ($urandom_range(0, 2)) begin
                  prog_counter = 5'($urandom);
                  tick();
               end
               checks++;
               if ({instr_valid, instruction} !== {1'b1, model_mem[pc]}) begin
                  failures++;
                  $display("FAIL rand_hold[%0d.%0d]: got valid=%b instr=%h, want 1/%h",
                           round, k, instr_valid, instruction, model_mem[pc]);
               end
               instr_ready = 1'b1; tick(); instr_ready = 1'b0;
            end else begin
               checks++;
               if ({done, instr_valid} !== 2'b10) begin
                  failures++;
                  $display("FAIL rand_done[%0d.%0d]: pc=%0d len=%0d got done=%b valid=%b, want 1/0",
                           round, k, pc, model_len, done, instr_valid);
               end
               break;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_halt();
      test_jump_loop();
      test_reload();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prog_fetch_unit.md
Name: prog_fetch_unit

Overview:
Program memory and instruction-fetch stage placed directly upstream of the execution control unit.
- Holds a 32-entry × 28-bit program, written through a load port while le_pm=1.
- Once le_pm falls, fetches the word at the consumer's prog_counter and presents it on instruction with a valid/ready handshake.
- Stops on a halt opcode or when prog_counter runs past the loaded program length.

Parameters:
INSTR_W, 28, instruction width {opcode[27:24], op1[23:16], op2[15:8], op3[7:0]}
DEPTH, 32, program memory entries
ADDR_W, 5, address / prog_counter width
HALT_OP, 4'hF, opcode that terminates fetch

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
le_pm  input  1  1 = program-load mode, 0 = run mode
load_we  input  1  write strobe for load port; honoured only when le_pm=1
load_addr  input  ADDR_W  program memory write address
load_data  input  INSTR_W  program word to write
prog_counter  input  ADDR_W  fetch address from the execution control unit
instr_ready  input  1  consumer accepts the presented instruction
instruction  output  INSTR_W  fetched instruction word
instr_valid  output  1  instruction is valid and held stable
prog_len  output  ADDR_W+1  number of loaded words (highest written address + 1)
done  output  1  fetch terminated (halt or end of program)

Behaviour:
- Reset: state IDLE; instruction=0; instr_valid=0; prog_len=0; done=0. Memory contents are not reset.
- State machine: IDLE, LOAD, FETCH, ISSUE, DONE.
- IDLE: le_pm=1 moves to LOAD; otherwise stay.
- le_pm=1 seen in any state moves to LOAD next cycle. On entry: prog_len←0, instr_valid←0, done←0. An in-flight instruction is dropped and never accepted.
- LOAD, write: on load_we=1, mem[load_addr]←load_data. prog_len←max(prog_len, load_addr+1), so the range is 0..32 (6 bits).
- LOAD, rewrite: rewriting an address is allowed; the last write wins.
- LOAD, exit: when le_pm=0, go to FETCH if prog_len≠0, else DONE.
- load_we with le_pm=0 is ignored in every state.
- FETCH: sample prog_counter.
  - If prog_counter ≥ prog_len, go to DONE.
  - Otherwise register mem[prog_counter] into instruction.
  - If the fetched opcode==HALT_OP, go to DONE with instr_valid=0; the halt word is never issued.
  - Otherwise go to ISSUE.
- ISSUE: instr_valid=1. instruction is held stable while instr_ready=0.
  - On the cycle with instr_valid=1 and instr_ready=1, the transfer completes. Next cycle: instr_valid=0, state FETCH.
  - The consumer must have prog_counter updated by that FETCH cycle, i.e. one cycle after acceptance.
- DONE: done=1, instr_valid=0. Stay until le_pm=1 or reset.
- Latency:
  - le_pm falling edge to first instr_valid=1: 2 cycles (LOAD→FETCH→ISSUE).
  - Accept to next instr_valid=1: 2 cycles.
- Jumps: prog_counter may change arbitrarily between accepts; fetch uses the value sampled in FETCH only. prog_counter changing during ISSUE has no effect.
- Width rules:
  - prog_counter compares against the 6-bit prog_len as zero-extended unsigned.
  - load_addr=31 yields prog_len=32, and all addresses are fetchable.
- Asynchronous reset mid-ISSUE clears instr_valid immediately. The program must be reloaded logically, since prog_len=0.

Test Plan:
- Load mem[0]=28'h0010A00, mem[1]=28'h1070605; drop le_pm; consumer steps pc 0,1,2 with ready=1 → instructions 0010A00 then 1070605, each valid 2 cycles after the previous accept; done=1 when pc=2; prog_len=2.
- Backpressure: hold instr_ready=0 for 5 cycles in ISSUE → instr_valid=1 and instruction unchanged throughout; a single accept on ready.
- Halt: mem[0]=28'h0010A00, mem[1]=28'hF000000, mem[2]=28'h1070605 → only 0010A00 issued; done=1 after FETCH of pc=1; mem[2] never presented.
- Jump loop: mem[0]=28'h6000000 plus a consumer that sets pc=op1 → instruction 6000000 reissued on every accept; done stays 0 for 20 accepts.
- Reload mid-run: assert le_pm during ISSUE → instr_valid=0 next cycle, prog_len=0; load_we with le_pm=0 afterwards leaves memory unchanged (verified by refetch).
- Async reset pulse while instr_valid=1 → instr_valid, done, prog_len go to 0 without waiting for a clock edge; state IDLE; no fetch until le_pm cycles.
